// File: rtl/burst_line_engine_pkg.sv
// Shared definitions for the cache-line <-> BurstRAM transfer engine.
// Holds the command codes, the FSM state encoding and the beat-counter width helper.
package burst_line_engine_pkg;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;
    localparam int   BEAT_BYTES   = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_BEATS,
        RD_BEATS,
        DONE
    } state_t;

    // Bits needed to count beat indices 0..n-1 (n is a power of two, n >= 2).
    function automatic int log2_beats(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/burst_line_engine.sv
// Moves one cache line per request as a single BurstRAM burst: serialises masked
// write beats or assembles returned read beats into rd_line.
import burst_line_engine_pkg::*;

module burst_line_engine #(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int LINE_BITWIDTH  = DATA_BITWIDTH * BURST_COUNT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [DEPTH_BITWIDTH-1:0]     req_addr,
    input  logic [LINE_BITWIDTH-1:0]      wr_line,
    input  logic [LINE_BITWIDTH/8-1:0]    wr_byte_en,
    output logic [LINE_BITWIDTH-1:0]      rd_line,
    output logic                          done,
    output logic                          err,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]     br_addr,
    output logic [DATA_BITWIDTH-1:0]      br_wr_data,
    output logic [BEAT_BYTES-1:0]         br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]      br_rd_data,
    input  logic                          br_rd_data_valid,
    input  logic                          br_busy
);

    localparam int CW          = log2_beats(BURST_COUNT);
    localparam int BE_BITWIDTH = LINE_BITWIDTH / 8;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);
    localparam logic [DEPTH_BITWIDTH-1:0] ALIGN_MASK = ~DEPTH_BITWIDTH'(BURST_COUNT - 1);

    state_t                    state_reg, state_next;
    logic [CW-1:0]             beat_reg;
    logic [CW-1:0]             beat_inc;
    logic                      write_reg;
    logic [LINE_BITWIDTH-1:0]  line_reg;
    logic [BE_BITWIDTH-1:0]    be_reg;
    logic                      accept;
    logic                      rd_capture;
    logic                      wr_step;

    logic [DATA_BITWIDTH-1:0]  wr_beats [BURST_COUNT];
    logic [BEAT_BYTES-1:0]     wr_masks [BURST_COUNT];

    generate
        for (genvar gi = 0; gi < BURST_COUNT; gi++) begin : g_beat_slices
            assign wr_beats[gi] = line_reg[gi*DATA_BITWIDTH +: DATA_BITWIDTH];
            assign wr_masks[gi] = ~be_reg[gi*BEAT_BYTES +: BEAT_BYTES];
        end
    endgenerate

    assign req_ready  = (state_reg == IDLE) && !br_busy && !rst;
    assign accept     = req_valid && req_ready;
    assign rd_capture = (state_reg == RD_BEATS) && br_rd_data_valid;
    assign wr_step    = ((state_reg == CMD) && write_reg) || (state_reg == WR_BEATS);
    assign beat_inc   = beat_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        case (state_reg)
            IDLE:     if (accept) state_next = CMD;
            CMD:      state_next = write_reg ? WR_BEATS : RD_BEATS;
            WR_BEATS: if (beat_reg == LAST_BEAT) state_next = DONE;
            RD_BEATS: if (rd_capture && (beat_reg == LAST_BEAT)) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Beat 0 of a write goes out alongside the command, so it comes straight from
    // the request; later beats come from the latched line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_reg     <= '0;
            write_reg    <= 1'b0;
            line_reg     <= '0;
            be_reg       <= '0;
            err          <= 1'b0;
            br_cmd       <= BR_CMD_READ;
            br_cmd_en    <= 1'b0;
            br_addr      <= '0;
            br_wr_data   <= '0;
            br_data_mask <= '1;
        end else begin
            br_cmd_en <= accept;
            if (accept) begin
                write_reg <= req_write;
                line_reg  <= wr_line;
                be_reg    <= wr_byte_en;
                br_cmd    <= req_write ? BR_CMD_WRITE : BR_CMD_READ;
                br_addr   <= req_addr & ALIGN_MASK;
                beat_reg  <= '0;
                if (req_write) begin
                    br_wr_data   <= wr_line[DATA_BITWIDTH-1:0];
                    br_data_mask <= ~wr_byte_en[BEAT_BYTES-1:0];
                end else begin
                    br_wr_data   <= '0;
                    br_data_mask <= '1;
                end
            end else if (wr_step) begin
                if ((state_reg == WR_BEATS) && (beat_reg == LAST_BEAT)) begin
                    br_wr_data   <= '0;
                    br_data_mask <= '1;
                    beat_reg     <= '0;
                end else begin
                    br_wr_data   <= wr_beats[beat_inc];
                    br_data_mask <= wr_masks[beat_inc];
                    beat_reg     <= beat_inc;
                end
            end else if (rd_capture) begin
                beat_reg <= beat_inc;
            end

            if (br_rd_data_valid && (state_reg != RD_BEATS)) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_line <= '0;
        end else if (rd_capture) begin
            for (int i = 0; i < BURST_COUNT; i++) begin
                if (beat_reg == CW'(i)) begin
                    rd_line[i*DATA_BITWIDTH +: DATA_BITWIDTH] <= br_rd_data;
                end
            end
        end
    end

endmodule
